// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters.
// Optional macro ALU_ARB_ERR_EN adds rsp_err, flagging the unused opcodes 101..111.
module alu_rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*WIDTH-1:0]    req_in1,
  input  logic [NREQ*WIDTH-1:0]    req_in2,
  input  logic [NREQ*3-1:0]        req_sel,
  output logic [WIDTH-1:0]         alu_in1,
  output logic [WIDTH-1:0]         alu_in2,
  output logic [2:0]               alu_sel,
  input  logic [WIDTH-1:0]         alu_out,
  output logic                     rsp_valid,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
`ifdef ALU_ARB_ERR_EN
  output logic                     rsp_err,
`endif
  input  logic                     rsp_ready
);

  localparam int IDW = $clog2(NREQ);
  localparam int IW  = IDW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [IDW-1:0]    ptr_r;
  logic [IDW-1:0]    ptr_nxt_s;
  logic [NREQ-1:0]   rot_s;
  logic [IDW-1:0]    off_s;
  logic [IDW-1:0]    grant_s;
  logic              any_valid_s;
  logic [WIDTH-1:0]  in1_s;
  logic [WIDTH-1:0]  in2_s;
  logic [2:0]        sel_s;
`ifdef ALU_ARB_ERR_EN
  logic              sel_err_s;
`endif

  // Modulo-NREQ addition that also works for non-power-of-two NREQ.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a, input logic [IDW-1:0] b);
    logic [IW-1:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= IW'(NREQ)) begin
      s = s - IW'(NREQ);
    end else begin
      s = s;
    end
    return s[IDW-1:0];
  endfunction

  // Rotate valids so ptr sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    any_valid_s = |req_valid;
    rot_s       = NREQ'({req_valid, req_valid} >> ptr_r);
    off_s       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      off_s = rot_s[k] ? IDW'(k) : off_s;
    end
    grant_s   = wrap_add(ptr_r, off_s);
    ptr_nxt_s = wrap_add(rsp_id, IDW'(1));
  end

  // Operand mux for the current winner.
  always_comb begin
    in1_s = '0;
    in2_s = '0;
    sel_s = 3'b000;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_s == IDW'(i)) begin
        in1_s = req_in1[i*WIDTH +: WIDTH];
        in2_s = req_in2[i*WIDTH +: WIDTH];
        sel_s = req_sel[i*3 +: 3];
      end else begin
        in1_s = in1_s;
        in2_s = in2_s;
        sel_s = sel_s;
      end
    end
  end

`ifdef ALU_ARB_ERR_EN
  // Opcodes above XOR are unused by the ALU.
  always_comb begin
    sel_err_s = (alu_sel >= 3'b101);
  end
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_valid_s) begin
          state_nxt_s = EXEC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXEC: state_nxt_s = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: one-hot accept to the winner while idle.
  always_comb begin
    req_ready = '0;
    if ((state_r == IDLE) && any_valid_s) begin
      req_ready = NREQ'(1) << grant_s;
    end else begin
      req_ready = '0;
    end
  end

  // Datapath: operand capture, result capture, pointer advance on response accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r     <= '0;
      alu_in1   <= '0;
      alu_in2   <= '0;
      alu_sel   <= 3'b000;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
`ifdef ALU_ARB_ERR_EN
      rsp_err   <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (any_valid_s) begin
            alu_in1 <= in1_s;
            alu_in2 <= in2_s;
            alu_sel <= sel_s;
            rsp_id  <= grant_s;
          end
        end
        EXEC: begin
          rsp_valid <= 1'b1;
`ifdef ALU_ARB_ERR_EN
          rsp_err   <= sel_err_s;
          rsp_data  <= sel_err_s ? '0 : alu_out;
`else
          rsp_data  <= alu_out;
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ptr_r     <= ptr_nxt_s;
`ifdef ALU_ARB_ERR_EN
            rsp_err   <= 1'b0;
`endif
          end
        end
        default: begin
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter (NREQ=4) with a behavioural ALU and a response scoreboard.
module tb_alu_rr_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*WIDTH-1:0] req_in1;
  logic [NREQ*WIDTH-1:0] req_in2;
  logic [NREQ*3-1:0] req_sel;
  logic [WIDTH-1:0]  alu_in1;
  logic [WIDTH-1:0]  alu_in2;
  logic [2:0]        alu_sel;
  logic [WIDTH-1:0]  alu_out;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic [WIDTH-1:0]  rsp_data;
  logic              rsp_ready;
  logic              rsp_err;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Shared ALU: 000 add, 001 sub, 010 and, 011 or, 100 xor, others 0.
  always_comb begin
    case (alu_sel)
      3'b000:  alu_out = alu_in1 + alu_in2;
      3'b001:  alu_out = alu_in1 - alu_in2;
      3'b010:  alu_out = alu_in1 & alu_in2;
      3'b011:  alu_out = alu_in1 | alu_in2;
      3'b100:  alu_out = alu_in1 ^ alu_in2;
      default: alu_out = 16'h0000;
    endcase
  end

  alu_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_in1   (req_in1),
    .req_in2   (req_in2),
    .req_sel   (req_sel),
    .alu_in1   (alu_in1),
    .alu_in2   (alu_in2),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
`ifdef ALU_ARB_ERR_EN
    .rsp_err   (rsp_err),
`endif
    .rsp_ready (rsp_ready)
  );

`ifndef ALU_ARB_ERR_EN
  assign rsp_err = 1'b0;
`endif

  task automatic set_req(input int i, input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] s);
    req_valid[i]          = v;
    req_in1[i*16 +: 16]   = a;
    req_in2[i*16 +: 16]   = b;
    req_sel[i*3 +: 3]     = s;
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [15:0] data, input logic err);
    exp_t e;
    e.id   = id;
    e.data = data;
    e.err  = err;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_in1   = '0;
    req_in2   = '0;
    req_sel   = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  // Called at a negedge; returns just after the negedge where some req_ready bit is high.
  task automatic wait_grant(output int g, output bit ok);
    ok = 1'b0;
    g  = -1;
    for (int n = 0; n < 30; n++) begin
      #1;
      if (req_ready != '0) begin
        ok = 1'b1;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Returns at the first negedge where rsp_valid is high.
  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_in1   = '0;
    req_in2   = '0;
    req_sel   = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (req_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 0000", req_ready);
    end
    vectors++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b0, 2'd0, 16'h0000}) begin
      miscompares++;
      $display("FAIL reset_rsp: got v=%b id=%0d d=%h want 0/0/0000", rsp_valid, rsp_id, rsp_data);
    end
    vectors++;
    if ({alu_in1, alu_in2, alu_sel} !== {16'h0000, 16'h0000, 3'b000}) begin
      miscompares++;
      $display("FAIL reset_alu: got %h %h %b want zeros", alu_in1, alu_in2, alu_sel);
    end
    vectors++;
    if (rsp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_err: got %b want 0", rsp_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_add();
    int g;
    bit ok;
    exp_t e;
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 1'b1, 16'h0005, 16'h0003, 3'b000);
    push_exp(2'd0, 16'h0008, 1'b0);
    wait_grant(g, ok);
    vectors++;
    if (!ok || g != 0) begin
      miscompares++;
      $display("FAIL add_grant: got %0d want 0", g);
    end
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    vectors++;
    if ({req_ready, rsp_valid} !== {4'b0000, 1'b0}) begin
      miscompares++;
      $display("FAIL add_exec: got ready=%b v=%b want 0000/0", req_ready, rsp_valid);
    end
    @(negedge clk);
    e = sb.pop_front();
    vectors++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, e.id, e.data}) begin
      miscompares++;
      $display("FAIL add_rsp: got v=%b id=%0d d=%h want 1/%0d/%h", rsp_valid, rsp_id, rsp_data, e.id, e.data);
    end
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL add_done: got v=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_two_rotate();
    int g;
    bit ok;
    exp_t e;
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 1'b1, 16'h0003, 16'h0005, 3'b001);
    set_req(1, 1'b1, 16'hFF00, 16'h0FF0, 3'b100);
    for (int k = 0; k < 4; k++) push_exp(2'(k % 2), (k % 2 == 0) ? 16'hFFFE : 16'hF0F0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      wait_grant(g, ok);
      vectors++;
      if (!ok || g != k % 2) begin
        miscompares++;
        $display("FAIL rot2_grant%0d: got %0d want %0d", k, g, k % 2);
      end
      wait_rsp(ok);
      e = sb.pop_front();
      vectors++;
      if (!ok || rsp_id !== e.id || rsp_data !== e.data) begin
        miscompares++;
        $display("FAIL rot2_rsp%0d: got id=%0d d=%h want %0d/%h", k, rsp_id, rsp_data, e.id, e.data);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    int g;
    bit ok;
    exp_t e;
    do_reset();
    set_req(1, 1'b1, 16'h00F0, 16'h000F, 3'b011);
    push_exp(2'd1, 16'h00FF, 1'b0);
    wait_grant(g, ok);
    vectors++;
    if (!ok || g != 1) begin
      miscompares++;
      $display("FAIL bp_grant: got %0d want 1", g);
    end
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    set_req(0, 1'b1, 16'h0001, 16'h0001, 3'b000);
    push_exp(2'd0, 16'h0002, 1'b0);
    wait_rsp(ok);
    e = sb.pop_front();
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (!ok || {rsp_valid, rsp_id, rsp_data, req_ready} !== {1'b1, e.id, e.data, 4'b0000}) begin
        miscompares++;
        $display("FAIL bp_hold%0d: got v=%b id=%0d d=%h rdy=%b want 1/%0d/%h/0000",
                 c, rsp_valid, rsp_id, rsp_data, req_ready, e.id, e.data);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    wait_grant(g, ok);
    vectors++;
    if (!ok || g != 0) begin
      miscompares++;
      $display("FAIL bp_next_grant: got %0d want 0", g);
    end
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    wait_rsp(ok);
    e = sb.pop_front();
    vectors++;
    if (!ok || rsp_id !== e.id || rsp_data !== e.data) begin
      miscompares++;
      $display("FAIL bp_next_rsp: got id=%0d d=%h want %0d/%h", rsp_id, rsp_data, e.id, e.data);
    end
  endtask

  task automatic test_err();
    int g;
    bit ok;
    exp_t e;
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 1'b1, 16'h1234, 16'h5678, 3'b110);
    push_exp(2'd0, 16'h0000, 1'b1);
    push_exp(2'd0, 16'h0006, 1'b0);
    for (int k = 0; k < 2; k++) begin
      wait_grant(g, ok);
      if (k == 0) begin
        @(posedge clk);
        #1 set_req(0, 1'b1, 16'h0004, 16'h0002, 3'b000);
      end else begin
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
      end
      wait_rsp(ok);
      e = sb.pop_front();
      vectors++;
      if (!ok || rsp_id !== e.id || rsp_data !== e.data) begin
        miscompares++;
        $display("FAIL err_rsp%0d: got id=%0d d=%h want %0d/%h", k, rsp_id, rsp_data, e.id, e.data);
      end
`ifdef ALU_ARB_ERR_EN
      vectors++;
      if (rsp_err !== e.err) begin
        miscompares++;
        $display("FAIL err_flag%0d: got %b want %b", k, rsp_err, e.err);
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    int g;
    bit ok;
    exp_t e;
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 1'b1, 16'h0001, 16'h0002, 3'b000);
    push_exp(2'd0, 16'h0003, 1'b0);
    wait_grant(g, ok);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    wait_rsp(ok);
    e = sb.pop_front();
    vectors++;
    if (!ok || rsp_id !== e.id || rsp_data !== e.data) begin
      miscompares++;
      $display("FAIL rstmid_pre: got id=%0d d=%h want %0d/%h", rsp_id, rsp_data, e.id, e.data);
    end
    set_req(1, 1'b1, 16'hFF0F, 16'h0FF0, 3'b010);
    push_exp(2'd1, 16'h0F00, 1'b0);
    wait_grant(g, ok);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rstmid_norsp%0d: got v=%b want 0", c, rsp_valid);
      end
    end
    set_req(0, 1'b1, 16'h0001, 16'h0001, 3'b000);
    set_req(1, 1'b1, 16'h0002, 16'h0002, 3'b000);
    push_exp(2'd0, 16'h0002, 1'b0);
    push_exp(2'd1, 16'h0004, 1'b0);
    for (int k = 0; k < 2; k++) begin
      wait_grant(g, ok);
      vectors++;
      if (!ok || g != k) begin
        miscompares++;
        $display("FAIL rstmid_grant%0d: got %0d want %0d", k, g, k);
      end
      @(posedge clk);
      #1 req_valid[k] = 1'b0;
      wait_rsp(ok);
      e = sb.pop_front();
      vectors++;
      if (!ok || rsp_id !== e.id || rsp_data !== e.data) begin
        miscompares++;
        $display("FAIL rstmid_rsp%0d: got id=%0d d=%h want %0d/%h", k, rsp_id, rsp_data, e.id, e.data);
      end
    end
  endtask

  task automatic test_back_to_back();
    int g;
    int t_prev;
    bit ok;
    exp_t e;
    do_reset();
    rsp_ready = 1'b1;
    t_prev    = 0;
    set_req(3, 1'b1, 16'h0007, 16'h0009, 3'b000);
    for (int k = 0; k < 3; k++) push_exp(2'd3, 16'h0010, 1'b0);
    for (int k = 0; k < 3; k++) begin
      wait_grant(g, ok);
      vectors++;
      if (!ok || g != 3 || (k > 0 && cyc - t_prev != 3)) begin
        miscompares++;
        $display("FAIL b2b_grant%0d: got id=%0d gap=%0d want 3/3", k, g, cyc - t_prev);
      end
      t_prev = cyc;
      wait_rsp(ok);
      e = sb.pop_front();
      vectors++;
      if (!ok || rsp_id !== e.id || rsp_data !== e.data) begin
        miscompares++;
        $display("FAIL b2b_rsp%0d: got id=%0d d=%h want %0d/%h", k, rsp_id, rsp_data, e.id, e.data);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_rotate_all();
    int g;
    bit ok;
    exp_t e;
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 16'(i) * 16'h0111, 16'h0001, 3'b000);
    for (int k = 0; k < 8; k++) push_exp(2'(k % 4), 16'(k % 4) * 16'h0111 + 16'h0001, 1'b0);
    for (int k = 0; k < 8; k++) begin
      wait_grant(g, ok);
      vectors++;
      if (!ok || g != k % 4) begin
        miscompares++;
        $display("FAIL rot4_grant%0d: got %0d want %0d", k, g, k % 4);
      end
      wait_rsp(ok);
      e = sb.pop_front();
      vectors++;
      if (!ok || rsp_id !== e.id || rsp_data !== e.data) begin
        miscompares++;
        $display("FAIL rot4_rsp%0d: got id=%0d d=%h want %0d/%h", k, rsp_id, rsp_data, e.id, e.data);
      end
    end
    req_valid = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_add();
    test_two_rotate();
    test_backpressure();
    test_err();
    test_reset_mid();
    test_back_to_back();
    test_rotate_all();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
